// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO that launches one byte per UART frame with a START pulse and tracks READY_TX.
// Sticky OVERFLOW flag is built only when UART_TX_FIFO_OVF_EN is defined; otherwise it is tied low.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WR_EN,
  input  logic [7:0]        WR_DATA,
  output logic              FULL,
  output logic              EMPTY,
  output logic [ADDR_W:0]   COUNT,
  input  logic              READY_TX,
  output logic              START,
  output logic [7:0]        DATA_TX,
  input  logic              CLR_OVF,
  output logic              OVERFLOW
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic              wr_ok;
  logic              pop;

  // FULL is the registered flag, so a write at full is dropped even if a pop frees a slot on this edge.
  assign wr_ok = WR_EN && !FULL;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!EMPTY && READY_TX) begin
          pop       = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!READY_TX) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (READY_TX) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    count_nxt = COUNT;
    case ({wr_ok, pop})
      2'b10:   count_nxt = COUNT + 1'b1;
      2'b01:   count_nxt = COUNT - 1'b1;
      default: count_nxt = COUNT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem[wr_ptr] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      COUNT   <= '0;
      EMPTY   <= 1'b1;
      FULL    <= 1'b0;
      START   <= 1'b0;
      DATA_TX <= 8'h00;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        DATA_TX <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      START <= pop;
      COUNT <= count_nxt;
      EMPTY <= (count_nxt == '0);
      FULL  <= (count_nxt == FULL_CNT);
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      OVERFLOW <= 1'b0;
    end else if (WR_EN && FULL) begin
      OVERFLOW <= 1'b1;
    end else if (CLR_OVF) begin
      OVERFLOW <= 1'b0;
    end
  end
`else
  logic unused_clr_ovf;
  assign unused_clr_ovf = CLR_OVF;
  assign OVERFLOW       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed phases plus a random byte stream, scored against a queue model.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ready_tx = 1'b1;
  logic       clr_ovf = 1'b0;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       start;
  logic [7:0] data_tx;
  logic       overflow;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
    .CLK(clk), .RESET(reset), .WR_EN(wr_en), .WR_DATA(wr_data),
    .FULL(full), .EMPTY(empty), .COUNT(count),
    .READY_TX(ready_tx), .START(start), .DATA_TX(data_tx),
    .CLR_OVF(clr_ovf), .OVERFLOW(overflow)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] mq[$];
  logic [7:0] sent[$];
  logic [7:0] expq[$];
  logic [7:0] m_data = 8'h00;
  logic       m_ovf = 1'b0;
  logic       prev_start = 1'b0;
  int         since_start = 100;
  bit         u_auto = 1'b0;
  int         u_phase = 0;
  int         u_cnt = 0;
  logic       exp_ovf_at_full;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: the model applies the pre-edge inputs, then all outputs are compared #1 after the edge.
  task automatic step();
    int   s;
    logic acc;
    logic ovf_set;
    s       = mq.size();
    acc     = wr_en && (s < DEPTH);
    ovf_set = wr_en && (s == DEPTH);
    @(posedge clk);
    #1;
    if (reset) begin
      mq.delete();
      m_data      = 8'h00;
      m_ovf       = 1'b0;
      since_start = 100;
      chk("rst_start", start, 0);
    end else begin
      if (start) begin
        chk("pulse_width", prev_start, 0);
        chk("start_spacing", since_start >= 4, 1);
        chk("start_nonempty", s > 0, 1);
        if (s > 0) m_data = mq.pop_front();
        sent.push_back(data_tx);
        since_start = 0;
        if (u_auto) begin
          u_phase = 1;
          u_cnt   = $urandom_range(0, 2);
        end
      end else begin
        since_start++;
      end
      if (acc) mq.push_back(wr_data);
`ifdef UART_TX_FIFO_OVF_EN
      if (ovf_set) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
`endif
    end
    prev_start = start;
    chk("count", count, mq.size());
    chk("full", full, mq.size() == DEPTH);
    chk("empty", empty, mq.size() == 0);
    chk("data_tx", data_tx, m_data);
    chk("overflow", overflow, m_ovf);
    if (u_auto && !start) begin
      if (u_phase == 1) begin
        if (u_cnt == 0) begin
          ready_tx = 1'b0;
          u_phase  = 2;
          u_cnt    = $urandom_range(1, 10);
        end else u_cnt--;
      end else if (u_phase == 2) begin
        if (u_cnt == 0) begin
          ready_tx = 1'b1;
          u_phase  = 0;
        end else u_cnt--;
      end
    end else if (u_auto && start && u_cnt == 0) begin
      ready_tx = 1'b0;
      u_phase  = 2;
      u_cnt    = $urandom_range(1, 10);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mq.size() > 0 || u_phase != 0) && n < 3000) begin
      step();
      n++;
    end
    chk("drain_timeout", n < 3000, 1);
  endtask

  initial begin
`ifdef UART_TX_FIFO_OVF_EN
    exp_ovf_at_full = 1'b1;
`else
    exp_ovf_at_full = 1'b0;
`endif
    // Reset and idle
    step();
    reset = 1'b0;
    chk("reset_count", count, 0);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_data", data_tx, 8'h00);
    chk("reset_ovf", overflow, 0);
    repeat (3) step();

    // Single byte: START two edges after the write edge
    wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    chk("lat_count1", count, 1);
    chk("lat_no_start_yet", start, 0);
    step();
    chk("lat_start", start, 1);
    chk("lat_data", data_tx, 8'hA5);
    step();
    chk("lat_pulse_end", start, 0);
    step();
    ready_tx = 1'b0;
    repeat (20) step();
    ready_tx = 1'b1;
    repeat (5) step();
    chk("single_count0", count, 0);
    chk("single_sent1", sent.size(), 1);

    // Burst 00..0F with the UART held busy, then a 17th write at full
    sent.delete();
    ready_tx = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
    end
    chk("burst_full", full, 1);
    chk("burst_count", count, 16);
    wr_data = 8'hFF;
    step();
    wr_en = 1'b0;
    chk("burst_ovf", overflow, exp_ovf_at_full);
    chk("burst_count_after_drop", count, 16);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("clr_ovf", overflow, 0);
    // Write and pop on the same edge at full: write lost, COUNT drops to 15
    u_auto = 1'b1;
    ready_tx = 1'b1;
    wr_en = 1'b1; wr_data = 8'hEE;
    step();
    wr_en = 1'b0;
    chk("simul_count15", count, 15);
    chk("simul_start", start, 1);
    drain();
    chk("burst_sent_n", sent.size(), 16);
    for (int i = 0; i < DEPTH && i < sent.size(); i++) chk("burst_order", sent[i], i);

    // Random 40-byte stream, writing whenever FULL=0
    sent.delete();
    expq.delete();
    begin
      int written;
      int guard;
      written = 0;
      guard = 0;
      while (written < 40 && guard < 5000) begin
        wr_en = !full;
        wr_data = 8'($urandom);
        if (wr_en) begin
          expq.push_back(wr_data);
          written++;
        end
        step();
        guard++;
      end
      chk("stream_timeout", guard < 5000, 1);
    end
    wr_en = 1'b0;
    drain();
    chk("stream_sent_n", sent.size(), 40);
    for (int i = 0; i < 40 && i < sent.size() && i < expq.size(); i++)
      chk("stream_order", sent[i], expq[i]);

    // Reset while in WAIT_DONE with 5 bytes queued
    u_auto = 1'b0;
    ready_tx = 1'b1;
    wr_en = 1'b1; wr_data = 8'h11;
    step();
    wr_en = 1'b0;
    step();
    chk("rstmid_start", start, 1);
    ready_tx = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h20 + i);
      step();
    end
    wr_en = 1'b0;
    step();
    chk("rstmid_count5", count, 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstmid_count0", count, 0);
    chk("rstmid_empty", empty, 1);
    ready_tx = 1'b1;
    repeat (8) step();
    chk("rstmid_no_start", start, 0);
    wr_en = 1'b1; wr_data = 8'h77;
    step();
    wr_en = 1'b0;
    step();
    chk("rstmid_idle_start", start, 1);
    chk("rstmid_idle_data", data_tx, 8'h77);
    step();
    ready_tx = 1'b0;
    repeat (3) step();
    ready_tx = 1'b1;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and launch sequencer directly upstream of the UART transmitter. Accepts bytes from the host side at up to one per clock, stores them in a circular FIFO, and pushes them to the UART one at a time. For each byte it drives DATA_TX and pulses START, then tracks READY_TX through each frame. It decouples bursty producers from the UART's serial rate, which is set by WORK_FR.

## Interface
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH).
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- WR_EN  input  1  write request; accepted when FULL=0.
- WR_DATA  input  8  byte to enqueue.
- FULL  output  1  COUNT==DEPTH.
- EMPTY  output  1  COUNT==0.
- COUNT  output  ADDR_W+1  registered occupancy, 0..DEPTH.
- READY_TX  input  1  from UART; high = transmitter idle.
- START  output  1  one-cycle launch pulse to UART.
- DATA_TX  output  8  byte being transmitted; stable from START until next START.
- CLR_OVF  input  1  clears OVERFLOW (see Configuration).
- OVERFLOW  output  1  sticky dropped-write flag (see Configuration).

## Operation
- Storage: DEPTH x 8 array; write pointer and read pointer are ADDR_W bits and wrap modulo DEPTH. Occupancy is tracked by COUNT, not by pointer comparison.
- Write: on an edge with WR_EN=1 and FULL=0, store WR_DATA at wr_ptr, then increment wr_ptr.
  - WR_EN=1 with FULL=1 drops the byte. This holds even if a pop occurs on the same edge.
- Launch FSM states: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
  - IDLE: if EMPTY=0 and READY_TX=1, do all of the following on the same edge, then go to SEND:
    - DATA_TX <= mem[rd_ptr];
    - increment rd_ptr;
    - START <= 1.
  - SEND: START <= 0; go to WAIT_BUSY.
  - WAIT_BUSY: stay until READY_TX=0 (UART accepted the byte), then go to WAIT_DONE. There is no timeout.
  - WAIT_DONE: stay until READY_TX=1, then go to IDLE.
- COUNT update per edge: +1 on an accepted write only; -1 on a pop only; unchanged when both or neither occur.
- Simultaneous write and pop with COUNT==DEPTH: the write is dropped and the pop proceeds, so COUNT becomes DEPTH-1.
- Simultaneous write and pop with 0<COUNT<DEPTH: both proceed and COUNT is unchanged.
- Write into an empty FIFO is not forwarded in the same cycle. The earliest pop is on the edge after COUNT becomes 1.
- DATA_TX holds its last value in every state except the IDLE launch edge.

## Timing
- Reset values (one edge with RESET=1):
  - wr_ptr=0, rd_ptr=0, COUNT=0;
  - EMPTY=1, FULL=0;
  - START=0, DATA_TX=8'h00;
  - OVERFLOW=0, FSM=IDLE.
- RESET mid-frame: FIFO contents are discarded and the FSM returns to IDLE. A START high at that edge reads 0 afterwards. The UART's frame in progress is not affected by this block.
- FULL, EMPTY and COUNT are registered and reflect the state after the most recent edge.
- Latency with READY_TX=1:
  - write accepted at edge N;
  - COUNT=1 after N;
  - pop at edge N+1;
  - START=1 during the cycle after N+1 (exactly one cycle).
- Minimum spacing between START pulses is 4 cycles. In practice it is one UART frame plus 2 cycles.
- READY_TX is sampled only in IDLE, WAIT_BUSY and WAIT_DONE; it is ignored in SEND.

## Configuration
- UART_TX_FIFO_OVF_EN defined:
  - OVERFLOW is set on any edge where WR_EN=1 and FULL=1.
  - OVERFLOW clears on an edge with CLR_OVF=1 and no new overflow; set wins when both occur on the same edge.
- UART_TX_FIFO_OVF_EN undefined: OVERFLOW is tied to 0, CLR_OVF is ignored, and no overflow logic is synthesised. Drop-on-full behaviour is unchanged.

## Test plan
- Reset, then idle: COUNT=0, EMPTY=1, FULL=0, START=0, DATA_TX=8'h00, OVERFLOW=0.
- Write 8'hA5 with READY_TX=1 held, then model READY_TX low 3 cycles later and high 20 cycles after that:
  - single START pulse 2 cycles after the write edge, with DATA_TX=8'hA5;
  - no second START;
  - COUNT returns to 0.
- Burst-write 8'h00..8'h0F (16 bytes) with READY_TX=0: FULL=1, COUNT=16.
  - A 17th write of 8'hFF is dropped and OVERFLOW=1 (macro defined).
  - CLR_OVF clears OVERFLOW.
  - After READY_TX is released, DATA_TX sequence is 00..0F in order and 8'hFF is never sent.
- Pointer wrap and full-boundary events, with a UART model echoing READY_TX:
  - stream 40 bytes, writing one byte whenever FULL=0;
  - all 40 are transmitted in order with no duplicates or losses;
  - a write and pop on the same edge at COUNT=16 yields COUNT=15 and the written byte is lost.
- Assert RESET while in WAIT_DONE holding 5 queued bytes:
  - after the edge, COUNT=0 and FSM is IDLE;
  - no START while READY_TX stays high and no writes occur.
- Build without UART_TX_FIFO_OVF_EN, then overfill: OVERFLOW stays 0 and data order still matches the drop-on-full rules.
